// File: rtl/data_memory_if.sv
// data_memory_if: request/response bundle between the datapath and the data memory.
//   master: drives MemRead, MemWrite, Funct3, Address, WriteData;
//           receives ReadData, Ready, Busy, AccessErr.
//   slave : the data memory side (directions mirrored).
interface data_memory_if;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Ready;
  logic        Busy;
  logic        AccessErr;

  modport master (
    output MemRead, MemWrite, Funct3, Address, WriteData,
    input  ReadData, Ready, Busy, AccessErr
  );

  modport slave (
    input  MemRead, MemWrite, Funct3, Address, WriteData,
    output ReadData, Ready, Busy, AccessErr
  );
endinterface

// File: rtl/data_memory.sv
// data_memory: word-organised RV32I data memory with configurable wait states.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (aborts any request in flight)
//   bus   : data_memory_if.slave
//     MemRead/MemWrite : request strobes (exactly one must be high to request)
//     Funct3           : 000 B, 001 H, 010 W, 100 BU, 101 HU
//     Address          : byte address; wraps modulo 4*DEPTH_WORDS
//     WriteData        : store data, low bytes used for B/H
//     ReadData         : extended load result, valid while Ready=1
//     Ready            : one-cycle response pulse
//     Busy             : request in flight (after acceptance through Ready)
//     AccessErr        : valid with Ready; misaligned or illegal access
module data_memory #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 1
) (
  input logic          clk,
  input logic          rst_n,
  data_memory_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  state_t          nextState;
  logic [3:0]      waitCnt;

  logic            reqWrite;
  logic [2:0]      reqFunct3;
  logic [AW+1:0]   reqAddr;
  logic [31:0]     reqData;

  logic [31:0]     mem [DEPTH_WORDS];
  logic [31:0]     readDataQ;
  logic            accessErrQ;

  logic            request;
  logic            accept;
  logic            lastWait;
  logic            commit;
  logic            curWrite;
  logic [2:0]      curFunct3;
  logic [AW+1:0]   curAddr;
  logic [31:0]     curData;
  logic [AW-1:0]   wordIdx;
  logic            curErr;
  logic [3:0]      byteEn;
  logic [31:0]     laneData;

  function automatic logic isAccessErr(input logic [2:0] f3, input logic [1:0] lo,
                                       input logic wr);
    logic err;
    err = 1'b0;
    case (f3)
      3'b000:  err = 1'b0;
      3'b001:  err = lo[0];
      3'b010:  err = |lo;
      3'b100:  err = wr;
      3'b101:  err = wr | lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [3:0] storeByteEn(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store data so every enabled lane sees the right bytes.
  function automatic logic [31:0] storeLanes(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] lanes;
    case (size)
      2'b00:   lanes = {4{wd[7:0]}};
      2'b01:   lanes = {2{wd[15:0]}};
      default: lanes = wd;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] loadExtend(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] lo);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] ext;
    b   = word[8*lo +: 8];
    h   = lo[1] ? word[31:16] : word[15:0];
    sb  = signed'(b);
    sh  = signed'(h);
    ext = '0;
    case (f3)
      3'b000:  ext = 32'(sb);
      3'b001:  ext = 32'(sh);
      3'b010:  ext = signed'(word);
      3'b100:  ext = signed'({24'b0, b});
      3'b101:  ext = signed'({16'b0, h});
      default: ext = '0;
    endcase
    return unsigned'(ext);
  endfunction

  // A new request is taken in IDLE or on the edge that ends the Ready cycle.
  always_comb begin
    request  = bus.MemRead ^ bus.MemWrite;
    accept   = request && (state == IDLE || state == RESP);
    lastWait = (state == WAIT) && (({1'b0, waitCnt} + 5'd1) == 5'(WAIT_STATES));
    commit   = lastWait || (accept && (WAIT_STATES == 0));

    // With zero wait states the access happens on the accepting edge itself,
    // so the live bus fields are used instead of the latched copy.
    curWrite  = accept ? bus.MemWrite         : reqWrite;
    curFunct3 = accept ? bus.Funct3           : reqFunct3;
    curAddr   = accept ? bus.Address[AW+1:0]  : reqAddr;
    curData   = accept ? bus.WriteData        : reqData;

    wordIdx  = curAddr[AW+1:2];
    curErr   = isAccessErr(curFunct3, curAddr[1:0], curWrite);
    byteEn   = storeByteEn(curFunct3[1:0], curAddr[1:0]);
    laneData = storeLanes(curFunct3[1:0], curData);
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (request) nextState = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT: if (lastWait) nextState = RESP;
      RESP: begin
        if (request) nextState = (WAIT_STATES == 0) ? RESP : WAIT;
        else         nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      waitCnt    <= '0;
      readDataQ  <= '0;
      accessErrQ <= 1'b0;
    end else begin
      state <= nextState;
      if (accept)              waitCnt <= '0;
      else if (state == WAIT)  waitCnt <= waitCnt + 4'd1;
      // Response fields are loaded on the edge entering RESP and cleared otherwise.
      readDataQ  <= (commit && !curWrite && !curErr)
                    ? loadExtend(mem[wordIdx], curFunct3, curAddr[1:0]) : '0;
      accessErrQ <= commit && curErr;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      reqWrite  <= bus.MemWrite;
      reqFunct3 <= bus.Funct3;
      reqAddr   <= bus.Address[AW+1:0];
      reqData   <= bus.WriteData;
    end
  end

  // Reset gates the commit so an aborted store never reaches the array.
  always_ff @(posedge clk) begin
    if (rst_n && commit && curWrite && !curErr) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= laneData[8*b +: 8];
      end
    end
  end

  assign bus.Ready     = (state == RESP);
  assign bus.Busy      = (state != IDLE);
  assign bus.ReadData  = readDataQ;
  assign bus.AccessErr = accessErrQ;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  localparam int WS = 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sbq[$];

  data_memory_if bus();

  data_memory #(.DEPTH_WORDS(64), .WAIT_STATES(WS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idleBus();
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.Funct3    = 3'b010;
    bus.Address   = '0;
    bus.WriteData = '0;
  endtask

  // Drive one request at a negedge, wait (bounded) for Ready, compare against the
  // scoreboard. Returns at the negedge inside the Ready cycle.
  task automatic doReq(input string tag, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] expRd, input logic expErr);
    int   lat;
    exp_t e;
    sbq.push_back('{rd: expRd, err: expErr});
    bus.MemRead   = !wr;
    bus.MemWrite  = wr;
    bus.Funct3    = f3;
    bus.Address   = addr;
    bus.WriteData = wd;
    @(posedge clk);
    @(negedge clk);
    idleBus();
    lat = 1;
    while (!bus.Ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, WS + 1);
    e = sbq.pop_front();
    if (bus.Ready) begin
      check({tag, "_rd"}, bus.ReadData, e.rd);
      check({tag, "_err"}, {31'b0, bus.AccessErr}, {31'b0, e.err});
    end
  endtask

  initial begin
    int readyCnt;
    int busyCnt;
    exp_t e;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idleBus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, bus.Ready}, 32'd0);
    check("rst_busy", {31'b0, bus.Busy}, 32'd0);
    check("rst_rdata", bus.ReadData, 32'd0);
    check("rst_err", {31'b0, bus.AccessErr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    doReq("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    @(negedge clk);

    // LW 0x10 with cycle-by-cycle timing
    sbq.push_back('{rd: 32'hDEADBEEF, err: 1'b0});
    bus.MemRead = 1'b1; bus.Funct3 = 3'b010; bus.Address = 32'h10;
    @(posedge clk);
    @(negedge clk);
    idleBus();
    check("lw_n1_busy", {31'b0, bus.Busy}, 32'd1);
    check("lw_n1_ready", {31'b0, bus.Ready}, 32'd0);
    @(negedge clk);
    check("lw_n2_busy", {31'b0, bus.Busy}, 32'd1);
    check("lw_n2_ready", {31'b0, bus.Ready}, 32'd1);
    e = sbq.pop_front();
    check("lw_n2_rd", bus.ReadData, e.rd);
    check("lw_n2_err", {31'b0, bus.AccessErr}, {31'b0, e.err});
    @(negedge clk);
    check("lw_n3_ready", {31'b0, bus.Ready}, 32'd0);
    check("lw_n3_busy", {31'b0, bus.Busy}, 32'd0);
    check("lw_n3_rd", bus.ReadData, 32'd0);

    doReq("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    doReq("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    doReq("lh10", 1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    doReq("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
    doReq("sb11", 1'b1, 3'b000, 32'h11, 32'h000000AA, 32'h0, 1'b0);
    doReq("lw10_sb", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);

    doReq("lw12_mis", 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
    doReq("sh13_mis", 1'b1, 3'b001, 32'h13, 32'h0000FFFF, 32'h0, 1'b1);
    doReq("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    doReq("sbu_store", 1'b1, 3'b100, 32'h10, 32'h00000055, 32'h0, 1'b1);
    doReq("lw10_after_err", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);
    doReq("lw110_wrap", 1'b0, 3'b010, 32'h110, 32'h0, 32'hDEADAAEF, 1'b0);
    doReq("sh12", 1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0, 1'b0);
    doReq("lw10_sh", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234AAEF, 1'b0);
    @(negedge clk);

    // MemRead pulsed while Busy must not produce a second response
    sbq.push_back('{rd: 32'h1234AAEF, err: 1'b0});
    bus.MemRead = 1'b1; bus.Funct3 = 3'b010; bus.Address = 32'h10;
    @(posedge clk);
    @(negedge clk);
    bus.Address = 32'h14;
    @(negedge clk);
    idleBus();
    check("busy_pulse_ready", {31'b0, bus.Ready}, 32'd1);
    e = sbq.pop_front();
    check("busy_pulse_rd", bus.ReadData, e.rd);
    readyCnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.Ready) readyCnt++;
    end
    check("busy_pulse_extra", readyCnt, 32'd0);

    // Both strobes together in IDLE are ignored
    bus.MemRead = 1'b1; bus.MemWrite = 1'b1; bus.Address = 32'h10;
    @(posedge clk);
    @(negedge clk);
    idleBus();
    readyCnt = 0;
    busyCnt  = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.Ready) readyCnt++;
      if (bus.Busy)  busyCnt++;
      @(negedge clk);
    end
    check("both_ready", readyCnt, 32'd0);
    check("both_busy", busyCnt, 32'd0);

    // Reset during WAIT aborts an in-flight store
    doReq("sw20", 1'b1, 3'b010, 32'h20, 32'h12345678, 32'h0, 1'b0);
    @(negedge clk);
    bus.MemWrite = 1'b1; bus.Funct3 = 3'b010; bus.Address = 32'h20;
    bus.WriteData = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    idleBus();
    check("abort_wait_busy", {31'b0, bus.Busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_rst_ready", {31'b0, bus.Ready}, 32'd0);
    check("abort_rst_busy", {31'b0, bus.Busy}, 32'd0);
    check("abort_rst_rdata", bus.ReadData, 32'd0);
    check("abort_rst_err", {31'b0, bus.AccessErr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    doReq("lw20_old", 1'b0, 3'b010, 32'h20, 32'h0, 32'h12345678, 1'b0);
    @(negedge clk);

    check("sb_empty", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
